// File: rtl/jtframe_joy_filter.sv
// Resynchronises and debounces two 16-bit joystick words, with optional per-player autofire on bits 4/5.
// Autofire logic is only built when JTFRAME_JOY_AUTOFIRE_EN is defined.
`timescale 1ns/1ps
module jtframe_joy_filter #(
    parameter int TICKW     = 8,
    parameter int DB_CNT    = 4,
    parameter int AF_FRAMES = 2
)(
    input  logic        rst,
    input  logic        clk,
    input  logic [15:0] joy1_raw,
    input  logic [15:0] joy2_raw,
    input  logic        vs,
    input  logic [1:0]  autofire,
    output logic [15:0] joy1,
    output logic [15:0] joy2,
    output logic        changed
);
    localparam logic [3:0] DB_LAST = 4'(DB_CNT - 1);

    logic [31:0]      s1, s, q, flip, joy_next;
    logic [3:0]       c [0:31];
    logic [TICKW-1:0] pre;
    logic             tick;

    assign tick = &pre;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= '0;
            s   <= '0;
            pre <= '0;
        end else begin
            s1  <= {joy2_raw, joy1_raw};
            s   <= s1;
            pre <= pre + TICKW'(1);
        end
    end

    // A bit flips on the tick where it has disagreed for DB_CNT consecutive ticks
    always_comb begin
        flip = '0;
        for (int i = 0; i < 32; i++)
            flip[i] = tick && (s[i] != q[i]) && (c[i] == DB_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
            for (int i = 0; i < 32; i++) c[i] <= '0;
        end else if (tick) begin
            q <= q ^ flip;
            for (int i = 0; i < 32; i++) begin
                if (s[i] == q[i] || flip[i]) c[i] <= '0;
                else                         c[i] <= c[i] + 4'd1;
            end
        end
    end

`ifdef JTFRAME_JOY_AUTOFIRE_EN
    localparam logic [3:0] AF_LAST = 4'(AF_FRAMES - 1);

    logic       vs_l, vs_edge;
    logic [1:0] phase;
    logic [3:0] a [0:1];

    assign vs_edge = vs & ~vs_l;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_l  <= 1'b0;
            phase <= 2'b11;
            a[0]  <= '0;
            a[1]  <= '0;
        end else begin
            vs_l <= vs;
            for (int p = 0; p < 2; p++) begin
                if (!(q[16*p+4] || q[16*p+5])) begin
                    phase[p] <= 1'b1;
                    a[p]     <= '0;
                end else if (vs_edge) begin
                    if (a[p] == AF_LAST) begin
                        phase[p] <= ~phase[p];
                        a[p]     <= '0;
                    end else begin
                        a[p] <= a[p] + 4'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        joy_next = q;
        for (int p = 0; p < 2; p++) begin
            joy_next[16*p+4] = q[16*p+4] & (phase[p] | ~autofire[p]);
            joy_next[16*p+5] = q[16*p+5] & (phase[p] | ~autofire[p]);
        end
    end
`else
    logic unused_af;
    assign unused_af = &{1'b0, vs, autofire};
    assign joy_next  = q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            joy1    <= '0;
            joy2    <= '0;
            changed <= 1'b0;
        end else begin
            joy1    <= joy_next[15:0];
            joy2    <= joy_next[31:16];
            changed <= |flip;
        end
    end
endmodule

// File: tb/tb_jtframe_joy_filter.sv
// Bench for jtframe_joy_filter: directed scenarios plus randomized traffic against a tick-level reference model.
`timescale 1ns/1ps
module tb_jtframe_joy_filter;
    localparam int TICKW     = 8;
    localparam int DB_CNT    = 4;
    localparam int AF_FRAMES = 2;
    localparam int TICKS     = 1 << TICKW;
`ifdef JTFRAME_JOY_AUTOFIRE_EN
    localparam bit AF_ON = 1'b1;
`else
    localparam bit AF_ON = 1'b0;
`endif

    logic        rst;
    logic        clk = 1'b0;
    logic [15:0] joy1_raw = '0, joy2_raw = '0;
    logic        vs = 1'b0;
    logic [1:0]  autofire = '0;
    logic [15:0] joy1, joy2;
    logic        changed;

    int checks = 0;
    int errors = 0;

    jtframe_joy_filter #(.TICKW(TICKW), .DB_CNT(DB_CNT), .AF_FRAMES(AF_FRAMES)) dut (
        .rst(rst), .clk(clk), .joy1_raw(joy1_raw), .joy2_raw(joy2_raw), .vs(vs),
        .autofire(autofire), .joy1(joy1), .joy2(joy2), .changed(changed)
    );

    always #5 clk = ~clk;

    // Reference: counts clocks since reset, a bit flips once DB_CNT consecutive
    // tick samples of the (2-clock delayed) raw value disagree with it.
    int          m_clk;
    logic [31:0] m_p1, m_p2, m_q, m_nq, m_out;
    int          m_run [32];
    bit          m_phase [2];
    int          m_frames [2];
    logic        m_vs_d;
    logic [15:0] e_joy1, e_joy2;
    logic        e_changed;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_clk = 0; m_p1 = '0; m_p2 = '0; m_q = '0; m_vs_d = 1'b0;
            for (int b = 0; b < 32; b++) m_run[b] = 0;
            for (int p = 0; p < 2; p++) begin m_phase[p] = 1'b1; m_frames[p] = 0; end
            e_joy1 = '0; e_joy2 = '0; e_changed = 1'b0;
        end else begin
            m_out = m_q;
            if (AF_ON)
                for (int p = 0; p < 2; p++)
                    if (autofire[p] && !m_phase[p]) begin
                        m_out[16*p+4] = 1'b0;
                        m_out[16*p+5] = 1'b0;
                    end
            e_joy1 = m_out[15:0];
            e_joy2 = m_out[31:16];
            m_nq = m_q;
            if (m_clk % TICKS == TICKS - 1)
                for (int b = 0; b < 32; b++) begin
                    if (m_p2[b] != m_q[b]) begin
                        m_run[b]++;
                        if (m_run[b] == DB_CNT) begin m_nq[b] = m_p2[b]; m_run[b] = 0; end
                    end else m_run[b] = 0;
                end
            e_changed = (m_nq != m_q);
            for (int p = 0; p < 2; p++) begin
                if (!(m_q[16*p+4] || m_q[16*p+5])) begin
                    m_phase[p] = 1'b1; m_frames[p] = 0;
                end else if (vs && !m_vs_d) begin
                    m_frames[p]++;
                    if (m_frames[p] == AF_FRAMES) begin m_phase[p] = !m_phase[p]; m_frames[p] = 0; end
                end
            end
            m_vs_d = vs;
            m_q    = m_nq;
            m_p2   = m_p1;
            m_p1   = {joy2_raw, joy1_raw};
            m_clk++;
        end
    end

    task automatic test_reset();
        int n, pulses;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (joy1 !== 16'h0) begin errors++; $display("FAIL reset_joy1 got %h want 0000", joy1); end
        checks++; if (joy2 !== 16'h0) begin errors++; $display("FAIL reset_joy2 got %h want 0000", joy2); end
        checks++; if (changed !== 1'b0) begin errors++; $display("FAIL reset_changed got %b want 0", changed); end
        rst = 1'b0;
        joy1_raw = 16'hFFFF;
        repeat (TICKS * DB_CNT + 200) @(negedge clk);
        checks++; if (joy1 !== 16'hFFFF) begin errors++; $display("FAIL pre_reset_joy1 got %h want ffff", joy1); end
        #2 rst = 1'b1;
        #1;
        checks++; if (joy1 !== 16'h0 || joy2 !== 16'h0 || changed !== 1'b0) begin
            errors++; $display("FAIL async_reset got %h/%h/%b want 0000/0000/0", joy1, joy2, changed);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = 0; pulses = 0;
        while (joy1 !== 16'hFFFF && n < 1200) begin
            @(negedge clk); n++;
            if (changed === 1'b1) pulses++;
        end
        checks++; if (n > 2 + DB_CNT * TICKS + 1 || n <= (DB_CNT - 1) * TICKS) begin
            errors++; $display("FAIL reset_release_latency got %0d clocks want <= %0d", n, 2 + DB_CNT * TICKS + 1);
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL reset_release_pulses got %0d want 1", pulses); end
        checks++; if (joy2 !== 16'h0) begin errors++; $display("FAIL reset_release_joy2 got %h want 0000", joy2); end
    endtask

    task automatic test_glitch();
        int n, pulses, early;
        joy2_raw = 16'h0;
        repeat (TICKS * DB_CNT + 50) @(negedge clk);
        pulses = 0; early = 0;
        joy2_raw[0] = 1'b1;
        repeat (3 * TICKS) begin @(negedge clk); if (joy2[0] !== 1'b0) early++; if (changed === 1'b1) pulses++; end
        joy2_raw[0] = 1'b0;
        repeat (TICKS) begin @(negedge clk); if (joy2[0] !== 1'b0) early++; if (changed === 1'b1) pulses++; end
        joy2_raw[0] = 1'b1;
        n = 0;
        while (joy2[0] !== 1'b1 && n < 1200) begin
            @(negedge clk); n++;
            if (changed === 1'b1) pulses++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL glitch_leak got %0d high samples want 0", early); end
        checks++; if (n < (DB_CNT - 1) * TICKS + 4 || n > DB_CNT * TICKS + 3) begin
            errors++; $display("FAIL glitch_latency got %0d clocks want %0d..%0d", n, (DB_CNT - 1) * TICKS + 4, DB_CNT * TICKS + 3);
        end
        repeat (20) begin @(negedge clk); if (changed === 1'b1) pulses++; end
        checks++; if (pulses != 1) begin errors++; $display("FAIL glitch_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_simultaneous();
        int n, c1, c2, pulses;
        c1 = -1; c2 = -1; n = 0; pulses = 0;
        joy1_raw[3] = 1'b0;
        joy2_raw[3] = 1'b1;
        while ((c1 < 0 || c2 < 0) && n < 1300) begin
            @(negedge clk); n++;
            if (changed === 1'b1) pulses++;
            if (c1 < 0 && joy1[3] === 1'b0) c1 = n;
            if (c2 < 0 && joy2[3] === 1'b1) c2 = n;
        end
        repeat (20) begin @(negedge clk); if (changed === 1'b1) pulses++; end
        checks++; if (c1 < 0 || c1 != c2) begin errors++; $display("FAIL simul_flip_cycle got %0d want %0d", c2, c1); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL simul_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_autofire();
        int n;
        bit want;
        autofire = 2'b01;
        joy1_raw = 16'h0; joy2_raw = 16'h0;
        repeat (TICKS * DB_CNT + 50) @(negedge clk);
        joy1_raw[4] = 1'b1; joy2_raw[4] = 1'b1;
        n = 0;
        while (joy1[4] !== 1'b1 && n < 1300) begin @(negedge clk); n++; end
        checks++; if (joy1[4] !== 1'b1 || joy2[4] !== 1'b1) begin
            errors++; $display("FAIL af_press got %b/%b want 1/1", joy1[4], joy2[4]);
        end
        for (int f = 1; f <= 6; f++) begin
            @(negedge clk); vs = 1'b1;
            @(negedge clk); vs = 1'b0;
            repeat (30) @(negedge clk);
            want = AF_ON ? ((f / AF_FRAMES) % 2 == 0) : 1'b1;
            checks++; if (joy1[4] !== want) begin errors++; $display("FAIL af_frame%0d got %b want %b", f, joy1[4], want); end
            checks++; if (joy2[4] !== 1'b1) begin errors++; $display("FAIL af_p2_frame%0d got %b want 1", f, joy2[4]); end
        end
        joy1_raw[4] = 1'b0;
        repeat (TICKS * DB_CNT + 50) @(negedge clk);
        checks++; if (joy1[4] !== 1'b0) begin errors++; $display("FAIL af_release got %b want 0", joy1[4]); end
        joy1_raw[4] = 1'b1;
        n = 0;
        while (joy1[4] !== 1'b1 && n < 1300) begin @(negedge clk); n++; end
        checks++; if (n < (DB_CNT - 1) * TICKS || n > DB_CNT * TICKS + 3) begin
            errors++; $display("FAIL af_repress_latency got %0d clocks want <= %0d", n, DB_CNT * TICKS + 3);
        end
    endtask

    task automatic test_random();
        logic [15:0] m;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            checks++;
            if ({joy1, joy2, changed} !== {e_joy1, e_joy2, e_changed}) begin
                errors++;
                $display("FAIL random cyc %0d got %h/%h/%b want %h/%h/%b", i, joy1, joy2, changed, e_joy1, e_joy2, e_changed);
            end
            if (i == 12000) begin
                #2 rst = 1'b1;
                #1;
                checks++; if ({joy1, joy2, changed} !== 33'h0) begin
                    errors++; $display("FAIL random_reset got %h/%h/%b want 0", joy1, joy2, changed);
                end
                @(negedge clk);
                rst = 1'b0;
            end
            if ($urandom_range(0, 299) == 0) begin
                m = 16'($urandom() & $urandom());
                if ($urandom_range(0, 1) == 1) m = m | 16'h0030;
                if ($urandom_range(0, 1) == 1) joy1_raw = joy1_raw ^ m;
                else                           joy2_raw = joy2_raw ^ m;
            end
            vs = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 2999) == 0) autofire = 2'($urandom_range(0, 3));
        end
        vs = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        test_reset();
        test_glitch();
        test_simultaneous();
        test_autofire();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
